mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of the data bus and the address bus.
REQ-002 Parameter TIMEOUT, default 255: maximum number of cycles to wait for ram_ack before a transaction is aborted; legal range 1..65535.
REQ-003 CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  fetch stage requests an instruction read.
REQ-006 if_addr  in  DATA_W  fetch address (the PC).
REQ-007 if_rdata  out  DATA_W  fetched instruction word.
REQ-008 if_done  out  1  one-cycle pulse: if_rdata is valid.
REQ-009 mem_rd, mem_wr  in  1 each  MEM stage load / store request; mutually exclusive.
REQ-010 mem_addr, mem_wdata  in  DATA_W each  data address; store data.
REQ-011 mem_rdata  out  DATA_W  load data.
REQ-012 mem_done  out  1  one-cycle pulse: load or store complete.
REQ-013 ram_req, ram_we  out  1 each  request to the unified single-port RAM; write enable.
REQ-014 ram_addr, ram_wdata  out  DATA_W each  RAM address; RAM write data.
REQ-015 ram_rdata  in  DATA_W  RAM read data, valid when ram_ack is high.
REQ-016 ram_ack  in  1  RAM transaction complete.
REQ-017 stall_if, stall_pipe  out  1 each  freeze PC and IF/ID; freeze ID/EX, EX/MEM and MEM/WB.
REQ-018 err_timeout  out  1  sticky flag: a transaction timed out.

Function
REQ-019 The FSM has exactly three states: IDLE, FETCH and DATA. At most one RAM transaction is outstanding at any time.
REQ-020 Transitions out of IDLE:
- a pending request is granted in the cycle it is sampled; the FSM moves to FETCH or DATA.
- at grant, the address, ram_we (=mem_wr) and write data are latched.
REQ-021 Arbitration when both fetch and data requests are pending:
- the grant goes to the requester not served last (last_grant register);
- after reset, last_grant = FETCH, so DATA wins the first tie.
REQ-022 RAM request timing:
- ram_req is registered; it is high from the cycle after grant until the cycle ram_ack is sampled high, inclusive.
- ram_addr, ram_we and ram_wdata stay stable for the whole transaction.
REQ-023 Completion (ram_ack sampled high in FETCH or DATA):
- ram_rdata is latched into if_rdata or mem_rdata; a store leaves mem_rdata unchanged;
- the matching done output pulses for exactly one cycle, starting the cycle after the ack;
- the FSM returns to IDLE and last_grant is updated.
REQ-024 Minimum latency is grant cycle t, ram_req high at t+1, ack at t+1, done at t+2. A new grant is possible at the earliest in the done cycle.
REQ-025 Requesters hold their request until done. A request deasserted mid-transaction does not abort it, and its done still pulses.
REQ-026 ram_ack while in IDLE is ignored.
REQ-027 stall_if = if_req & ~if_done (combinational).
REQ-028 stall_pipe = (mem_rd | mem_wr) & ~mem_done (combinational).
REQ-029 Timeout watchdog:
- a cycle counter clears at grant and increments while ram_req is high;
- when it reaches TIMEOUT without an ack, ram_req drops, err_timeout sets, the owner's done pulses with rdata unchanged, and the FSM returns to IDLE;
- err_timeout clears only on reset.
REQ-030 mem_rd and mem_wr high together is treated as a write.

Reset
REQ-031 While RST is high, the following are held at their reset values, taking effect immediately and independent of CLK:
- state = IDLE, last_grant = FETCH;
- ram_req, ram_we, if_done, mem_done and err_timeout = 0;
- ram_addr, ram_wdata, if_rdata, mem_rdata and the watchdog counter = 0.
REQ-032 Reset in the middle of a transaction abandons it: no done pulse is produced and ram_req falls in the same cycle.

Structure
REQ-033 Package mem_arb_pkg holds the state enumeration (IDLE, FETCH, DATA), the grant encoding, and the default DATA_W and TIMEOUT constants.
REQ-034 The watchdog is a separate sub-module, arb_watchdog, with inputs clear and enable and output expired. All other logic lives in mem_port_arbiter.

Verification
REQ-035 Single fetch: if_req=1, if_addr=0x40, ack after 3 cycles with ram_rdata=0x8C220004 -> ram_we=0, ram_addr=0x40, if_done pulses once, if_rdata=0x8C220004, stall_if low from the done cycle onward.
REQ-036 Tie after reset: if_req and mem_rd both asserted in cycle 0 -> DATA is granted first; FETCH is granted in the mem_done cycle; ram_addr follows the order mem_addr then if_addr.
REQ-037 Store: mem_wr=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, ack at 1 cycle -> ram_we=1, ram_wdata=0xDEADBEEF, mem_done pulses at t+2, mem_rdata unchanged.
REQ-038 Timeout: TIMEOUT=4, fetch request, ram_ack never asserted -> ram_req stays high for 4 cycles, err_timeout=1 (sticky), if_done pulses, FSM returns to IDLE.
REQ-039 Reset mid-operation: assert RST asynchronously (off a CLK edge) during DATA -> ram_req drops in the same cycle, no mem_done pulse, all outputs at reset values; a fetch after reset completes normally.
REQ-040 Back-to-back fairness: if_req and mem_rd held continuously for 6 transactions with 1-cycle acks -> grants alternate DATA, FETCH, DATA, …; neither requester starves.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and defaults for the unified memory-port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned c_default_data_w  = 32;
    localparam int unsigned c_default_timeout = 255;
    localparam int unsigned c_wdog_w          = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    // On a tie the requester that was not served last wins.
    function automatic grant_e pick_grant(input logic   fetch_pend,
                                          input logic   data_pend,
                                          input grant_e last_grant);
        if (fetch_pend && data_pend) begin
            return (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end
        return data_pend ? GNT_DATA : GNT_FETCH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Fetch, MEM-stage and RAM signals of the memory-port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_W = mem_arb_pkg::c_default_data_w
);
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              ram_req;
    logic              ram_we;
    logic [DATA_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;
    logic              stall_if;
    logic              stall_pipe;
    logic              err_timeout;

    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
               ram_rdata, ram_ack,
        output if_rdata, if_done, mem_rdata, mem_done, ram_req, ram_we,
               ram_addr, ram_wdata, stall_if, stall_pipe, err_timeout
    );

    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
               ram_rdata, ram_ack,
        input  if_rdata, if_done, mem_rdata, mem_done, ram_req, ram_we,
               ram_addr, ram_wdata, stall_if, stall_pipe, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : arb_watchdog
//  Description : Cycle counter flagging a RAM transaction that never acks.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment would reach TIMEOUT.
    assign expired = enable && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Fair arbiter sharing one single-port RAM between IF and MEM.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = c_default_data_w,
    parameter int unsigned TIMEOUT = c_default_timeout
) (
    input wire logic           clk,
    input wire logic           rst,
    mem_port_arbiter_if.slave  bus
);
    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    grant_e            r_last_grant;
    grant_e            w_grant;
    logic              w_fetch_pend;
    logic              w_data_pend;
    logic              w_start;
    logic              w_finish;
    logic              w_expired;

    logic              r_ram_req;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_done;
    logic              r_mem_done;
    logic              r_err_timeout;

    // A requester whose done is pulsing has been served; it is not re-granted.
    assign w_fetch_pend = bus.if_req & ~r_if_done;
    assign w_data_pend  = (bus.mem_rd | bus.mem_wr) & ~r_mem_done;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (c_wdog_w)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_start),
        .enable  (r_ram_req),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = r_last_grant;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fetch_pend || w_data_pend) begin
                    w_start     = 1'b1;
                    w_grant     = pick_grant(w_fetch_pend, w_data_pend, r_last_grant);
                    w_state_nxt = (w_grant == GNT_DATA) ? DATA : FETCH;
                end
            end
            FETCH, DATA: begin
                if (bus.ram_ack || w_expired) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant  <= GNT_FETCH;
            r_ram_req     <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_if_rdata    <= '0;
            r_mem_rdata   <= '0;
            r_if_done     <= 1'b0;
            r_mem_done    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            if (w_start) begin
                r_ram_req <= 1'b1;
                if (w_grant == GNT_DATA) begin
                    r_ram_addr  <= bus.mem_addr;
                    r_ram_we    <= bus.mem_wr;
                    r_ram_wdata <= bus.mem_wdata;
                end else begin
                    r_ram_addr  <= bus.if_addr;
                    r_ram_we    <= 1'b0;
                    r_ram_wdata <= '0;
                end
            end
            if (w_finish) begin
                r_ram_req <= 1'b0;
                if (r_state == DATA) begin
                    r_last_grant <= GNT_DATA;
                    r_mem_done   <= 1'b1;
                    if (bus.ram_ack && !r_ram_we) begin
                        r_mem_rdata <= bus.ram_rdata;
                    end
                end else begin
                    r_last_grant <= GNT_FETCH;
                    r_if_done    <= 1'b1;
                    if (bus.ram_ack) begin
                        r_if_rdata <= bus.ram_rdata;
                    end
                end
                // An ack in the final watchdog cycle still counts as success.
                if (!bus.ram_ack) begin
                    r_err_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.ram_req     = r_ram_req;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.if_done     = r_if_done;
    assign bus.mem_rdata   = r_mem_rdata;
    assign bus.mem_done    = r_mem_done;
    assign bus.err_timeout = r_err_timeout;
    assign bus.stall_if    = bus.if_req & ~r_if_done;
    assign bus.stall_pipe  = (bus.mem_rd | bus.mem_wr) & ~r_mem_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench: directed scenarios plus random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int unsigned TB_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(32)) bus();

    mem_port_arbiter #(
        .DATA_W  (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: one transaction in flight, owner 1 = data, 0 = fetch.
    bit          m_busy, m_own, m_we, m_last;
    int          m_elapsed;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
    bit          m_if_done, m_mem_done, m_err;

    bit rsp_pend;
    int rsp_wait;

    function automatic void model_reset();
        m_busy = 0; m_own = 0; m_we = 0; m_last = 0; m_elapsed = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
        m_if_done = 0; m_mem_done = 0; m_err = 0;
    endfunction

    task automatic model_step();
        bit f_el, d_el, nf, nd;
        if (rst) begin
            model_reset();
            return;
        end
        f_el = bus.if_req && !m_if_done;
        d_el = (bus.mem_rd || bus.mem_wr) && !m_mem_done;
        nf = 0;
        nd = 0;
        if (m_busy) begin
            m_elapsed++;
            if (bus.ram_ack || m_elapsed >= int'(TB_TIMEOUT)) begin
                m_busy = 0;
                m_last = m_own;
                if (!bus.ram_ack) m_err = 1;
                if (m_own) begin
                    nd = 1;
                    if (bus.ram_ack && !m_we) m_mem_rdata = bus.ram_rdata;
                end else begin
                    nf = 1;
                    if (bus.ram_ack) m_if_rdata = bus.ram_rdata;
                end
            end
        end else if (f_el || d_el) begin
            m_own     = (f_el && d_el) ? !m_last : d_el;
            m_busy    = 1;
            m_elapsed = 0;
            if (m_own) begin
                m_addr = bus.mem_addr; m_we = bus.mem_wr; m_wdata = bus.mem_wdata;
            end else begin
                m_addr = bus.if_addr; m_we = 0;
            end
        end
        m_if_done  = nf;
        m_mem_done = nd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ram_req", 32'(bus.ram_req), 32'(m_busy));
        if (m_busy) begin
            chk("ram_addr", bus.ram_addr, m_addr);
            chk("ram_we", 32'(bus.ram_we), 32'(m_we));
            if (m_we) chk("ram_wdata", bus.ram_wdata, m_wdata);
        end
        chk("if_done", 32'(bus.if_done), 32'(m_if_done));
        chk("mem_done", 32'(bus.mem_done), 32'(m_mem_done));
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("mem_rdata", bus.mem_rdata, m_mem_rdata);
        chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));
        chk("stall_if", 32'(bus.stall_if), 32'(bus.if_req & !m_if_done));
        chk("stall_pipe", 32'(bus.stall_pipe), 32'((bus.mem_rd | bus.mem_wr) & !m_mem_done));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.if_req = 0; bus.mem_rd = 0; bus.mem_wr = 0; bus.ram_ack = 0;
        bus.if_addr = '0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.ram_rdata = '0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic drive_random();
        int sel;
        if (!bus.if_req || bus.if_done) begin
            bus.if_req  = ($urandom_range(0, 2) != 0);
            bus.if_addr = $urandom() & 32'hFFFF_FFFC;
        end else if ($urandom_range(0, 19) == 0) begin
            bus.if_req = 1'b0;
        end
        if (!(bus.mem_rd || bus.mem_wr) || bus.mem_done) begin
            sel = int'($urandom_range(0, 7));
            bus.mem_rd    = (sel inside {1, 2, 3, 7});
            bus.mem_wr    = (sel inside {4, 5, 7});
            bus.mem_addr  = $urandom();
            bus.mem_wdata = $urandom();
        end else if ($urandom_range(0, 19) == 0) begin
            bus.mem_rd = 1'b0;
            bus.mem_wr = 1'b0;
        end
        // RAM: random latency 0..5 extra cycles; stray acks while idle.
        if (!bus.ram_req) begin
            rsp_pend    = 0;
            bus.ram_ack = ($urandom_range(0, 5) == 0);
        end else begin
            if (!rsp_pend) begin
                rsp_pend = 1;
                rsp_wait = int'($urandom_range(0, 5));
            end
            bus.ram_ack = (rsp_wait == 0);
            if (rsp_wait > 0) rsp_wait--;
        end
        bus.ram_rdata = $urandom();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] fair_q[$];
        logic [31:0] fair_exp [6];
        int          budget;
        int          nreq;

        fair_exp = '{32'h2000, 32'h1000, 32'h2000, 32'h1000, 32'h2000, 32'h1000};
        rsp_pend = 0;
        rsp_wait = 0;

        // Reset values
        do_reset();
        chk("rst_ram_req", 32'(bus.ram_req), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_addr", bus.ram_addr, 32'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);

        // Single fetch, ack in the third ram_req cycle
        bus.if_req = 1; bus.if_addr = 32'h40;
        cycle();
        chk("fetch_req", 32'(bus.ram_req), 32'd1);
        chk("fetch_addr", bus.ram_addr, 32'h40);
        chk("fetch_we", 32'(bus.ram_we), 32'd0);
        cycle();
        cycle();
        bus.ram_ack = 1; bus.ram_rdata = 32'h8C22_0004;
        cycle();
        bus.ram_ack = 0;
        chk("fetch_done", 32'(bus.if_done), 32'd1);
        chk("fetch_rdata", bus.if_rdata, 32'h8C22_0004);
        chk("fetch_stall_done", 32'(bus.stall_if), 32'd0);
        bus.if_req = 0;
        cycle();
        chk("fetch_done_once", 32'(bus.if_done), 32'd0);
        chk("fetch_stall_after", 32'(bus.stall_if), 32'd0);

        // Store with immediate ack
        bus.mem_wr = 1; bus.mem_addr = 32'h100; bus.mem_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("store_we", 32'(bus.ram_we), 32'd1);
        chk("store_addr", bus.ram_addr, 32'h100);
        chk("store_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        bus.ram_ack = 1; bus.ram_rdata = 32'h1234_5678;
        cycle();
        chk("store_done", 32'(bus.mem_done), 32'd1);
        chk("store_rdata_kept", bus.mem_rdata, 32'd0);
        bus.mem_wr = 0; bus.ram_ack = 0;
        cycle();
        chk("store_done_once", 32'(bus.mem_done), 32'd0);

        // Tie right after reset: data first, fetch granted in mem_done cycle
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.mem_rd = 1; bus.mem_addr = 32'h300;
        cycle();
        chk("tie_first_addr", bus.ram_addr, 32'h300);
        bus.ram_ack = 1; bus.ram_rdata = 32'h0000_A5A5;
        cycle();
        chk("tie_mem_done", 32'(bus.mem_done), 32'd1);
        chk("tie_mem_rdata", bus.mem_rdata, 32'h0000_A5A5);
        bus.mem_rd = 0; bus.ram_ack = 0;
        cycle();
        chk("tie_second_req", 32'(bus.ram_req), 32'd1);
        chk("tie_second_addr", bus.ram_addr, 32'h200);
        bus.ram_ack = 1; bus.ram_rdata = 32'h0000_5A5A;
        cycle();
        chk("tie_if_rdata", bus.if_rdata, 32'h0000_5A5A);
        bus.if_req = 0; bus.ram_ack = 0;
        cycle();

        // Back-to-back fairness with continuous requests and 1-cycle acks
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h1000;
        bus.mem_rd = 1; bus.mem_addr = 32'h2000;
        budget = 60;
        while (fair_q.size() < 6 && budget > 0) begin
            bus.ram_ack   = bus.ram_req;
            bus.ram_rdata = $urandom();
            if (bus.ram_req) fair_q.push_back(bus.ram_addr);
            cycle();
            budget--;
        end
        chk("fair_count", 32'(fair_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < fair_q.size(); i++) begin
            chk($sformatf("fair_order%0d", i), fair_q[i], fair_exp[i]);
        end
        bus.if_req = 0; bus.mem_rd = 0; bus.ram_ack = 0;
        cycle();
        cycle();

        // Watchdog: no ack ever
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h44;
        cycle();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.if_done) break;
            if (bus.ram_req) nreq++;
            cycle();
        end
        chk("to_req_cycles", 32'(nreq), 32'd4);
        chk("to_done", 32'(bus.if_done), 32'd1);
        chk("to_err", 32'(bus.err_timeout), 32'd1);
        chk("to_rdata_kept", bus.if_rdata, 32'd0);
        bus.if_req = 0;
        cycle();
        cycle();
        chk("to_idle", 32'(bus.ram_req), 32'd0);
        chk("to_err_sticky", 32'(bus.err_timeout), 32'd1);

        // Asynchronous reset in the middle of a load
        bus.mem_rd = 1; bus.mem_addr = 32'h300;
        cycle();
        cycle();
        chk("mid_req_before", 32'(bus.ram_req), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_req_drop", 32'(bus.ram_req), 32'd0);
        chk("mid_err_clear", 32'(bus.err_timeout), 32'd0);
        check_all();
        cycle();
        rst = 1'b0; bus.mem_rd = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("mid_no_done", 32'(bus.mem_done), 32'd0);
        end
        bus.if_req = 1; bus.if_addr = 32'h80;
        cycle();
        bus.ram_ack = 1; bus.ram_rdata = 32'h1357_9BDF;
        cycle();
        chk("post_rst_done", 32'(bus.if_done), 32'd1);
        chk("post_rst_rdata", bus.if_rdata, 32'h1357_9BDF);
        bus.if_req = 0; bus.ram_ack = 0;
        cycle();

        // Random traffic against the model
        rsp_pend = 0;
        for (int i = 0; i < 4000; i++) begin
            drive_random();
            cycle();
        end
        bus.if_req = 0; bus.mem_rd = 0; bus.mem_wr = 0;
        for (int i = 0; i < 12; i++) begin
            bus.ram_ack = bus.ram_req;
            cycle();
        end
        chk("drain_idle", 32'(bus.ram_req), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
